// File: rtl/fpu_cmd_regs.sv
// Purpose: memory-mapped command/status block that launches FPU operations and queues their results.
// Latency: register writes take effect on the next clk edge; rddata is combinational; inter_gen lags state by one cycle.
// Backpressure: cmd_valid holds until cmd_ready; a result arriving on a full FIFO is dropped and flagged in STATUS.ovf.
//
// Ports:
//   clk, rst_l                     - clock and synchronous active-low reset
//   addr, wren, rden, wrdata       - bus access into the 32-bit register map at BASE_ADDR
//   rddata                         - combinational read data for addr (RESULT read pops the FIFO head)
//   opA, opB, opC, frm, op_valids  - operand, rounding-mode and latched one-hot operation registers
//   cmd_valid, cmd_ready           - launch handshake towards the FPU
//   fpu_result, fpu_valids, exceptions - FPU completion inputs
//   inter_gen                      - registered level interrupt
module fpu_cmd_regs #(
    parameter logic [31:0]        BASE_ADDR  = 32'h3000_0000,
    parameter int                 NUM_OPS    = 13,
    parameter int                 DEPTH      = 4,
    parameter logic [NUM_OPS-1:0] VALID_MASK = 13'h1FFC
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic [31:0]        addr,
    input  logic               wren,
    input  logic               rden,
    input  logic [31:0]        wrdata,
    output logic [31:0]        rddata,
    output logic [31:0]        opA,
    output logic [31:0]        opB,
    output logic [31:0]        opC,
    output logic [2:0]         frm,
    output logic [NUM_OPS-1:0] op_valids,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    input  logic [31:0]        fpu_result,
    input  logic [NUM_OPS-1:0] fpu_valids,
    input  logic [4:0]         exceptions,
    output logic               inter_gen
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = NUM_OPS + 32;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [31:0] OFF_A      = 32'h00;
    localparam logic [31:0] OFF_B      = 32'h04;
    localparam logic [31:0] OFF_C      = 32'h08;
    localparam logic [31:0] OFF_RESULT = 32'h0C;
    localparam logic [31:0] OFF_RES_OP = 32'h10;
    localparam logic [31:0] OFF_STATUS = 32'h14;
    localparam logic [31:0] OFF_IRQ_EN = 32'h18;
    localparam logic [31:0] OFF_OPER   = 32'h1C;
    localparam logic [31:0] OFF_FFLAGS = 32'h20;
    localparam logic [31:0] OFF_FRM    = 32'h24;
    localparam logic [31:0] OFF_FCSR   = 32'h28;

    // Result FIFO: each entry is {op tag, result word}
    logic [EW-1:0] fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          busy_q;
    logic          cmd_err_q;
    logic          ovf_q;
    logic [2:0]    irq_en_q;
    logic [4:0]    fflags_q;

    logic [31:0]   off;
    logic          fifo_empty;
    logic          fifo_full;
    logic          result_hit;
    logic          pop;
    logic          push;
    logic          ovf_set;
    logic          op_wr;
    logic          op_wr_ok;
    logic          op_wr_err;
    logic          wr_status;

    logic [4:0]    fflags_n;
    logic [2:0]    frm_n;
    logic          cmd_err_n;
    logic          ovf_n;
    logic          busy_n;
    logic          cmd_valid_n;
    logic [CW-1:0] count_n;

    logic [31:0]   head_res;
    logic [31:0]   head_op_ext;
    logic [31:0]   op_ext;
    logic [31:0]   count_ext;

    // Upper wrdata bits are don't-care for the narrow registers
    logic          unused_wrdata;
    assign unused_wrdata = ^wrdata;

    assign off        = addr - BASE_ADDR;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL);
    assign result_hit = |(fpu_valids & VALID_MASK);

    // An empty-FIFO RESULT read is a no-op, so pop only qualifies with data present
    assign pop        = rden && (off == OFF_RESULT) && !fifo_empty;
    // A full FIFO still accepts a result when the head leaves in the same cycle
    assign push       = result_hit && (!fifo_full || pop);
    assign ovf_set    = result_hit && fifo_full && !pop;

    assign op_wr      = wren && (off == OFF_OPER) && (|wrdata[NUM_OPS-1:0]);
    assign op_wr_ok   = op_wr && !busy_q;
    assign op_wr_err  = op_wr && busy_q;
    assign wr_status  = wren && (off == OFF_STATUS);

    always_comb begin
        fflags_n = fflags_q;
        if (wren && ((off == OFF_FFLAGS) || (off == OFF_FCSR))) begin
            fflags_n = wrdata[4:0];
        end
        // Exceptions from a completing result accumulate on top of any same-cycle write
        if (result_hit) begin
            fflags_n = fflags_n | exceptions;
        end

        frm_n = frm;
        if (wren && (off == OFF_FRM)) begin
            frm_n = wrdata[2:0];
        end else if (wren && (off == OFF_FCSR)) begin
            frm_n = wrdata[7:5];
        end

        // Sticky bits: write-1-to-clear, a same-cycle set takes priority
        cmd_err_n = cmd_err_q;
        if (wr_status && wrdata[10]) begin
            cmd_err_n = 1'b0;
        end
        if (op_wr_err) begin
            cmd_err_n = 1'b1;
        end

        ovf_n = ovf_q;
        if (wr_status && wrdata[9]) begin
            ovf_n = 1'b0;
        end
        if (ovf_set) begin
            ovf_n = 1'b1;
        end

        busy_n = busy_q;
        if (result_hit) begin
            busy_n = 1'b0;
        end
        if (op_wr_ok) begin
            busy_n = 1'b1;
        end

        cmd_valid_n = cmd_valid;
        if (cmd_valid && cmd_ready) begin
            cmd_valid_n = 1'b0;
        end
        if (op_wr_ok) begin
            cmd_valid_n = 1'b1;
        end

        count_n = count;
        if (push && !pop) begin
            count_n = count + CW'(1);
        end else if (pop && !push) begin
            count_n = count - CW'(1);
        end
    end

    always_comb begin
        head_res    = '0;
        head_op_ext = '0;
        if (!fifo_empty) begin
            head_res                 = fifo_mem[rd_ptr][31:0];
            head_op_ext[NUM_OPS-1:0] = fifo_mem[rd_ptr][EW-1:32];
        end
        op_ext                 = '0;
        op_ext[NUM_OPS-1:0]    = op_valids;
        count_ext              = '0;
        count_ext[CW-1:0]      = count;
    end

    always_comb begin
        rddata = '0;
        case (off)
            OFF_A:      rddata = opA;
            OFF_B:      rddata = opB;
            OFF_C:      rddata = opC;
            OFF_RESULT: rddata = head_res;
            OFF_RES_OP: rddata = head_op_ext;
            OFF_STATUS: rddata = {21'b0, cmd_err_q, ovf_q, busy_q, count_ext[7:0]};
            OFF_IRQ_EN: rddata = {29'b0, irq_en_q};
            OFF_OPER:   rddata = op_ext;
            OFF_FFLAGS: rddata = {27'b0, fflags_q};
            OFF_FRM:    rddata = {29'b0, frm};
            OFF_FCSR:   rddata = {24'b0, frm, fflags_q};
            default:    rddata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            opA       <= '0;
            opB       <= '0;
            opC       <= '0;
            op_valids <= '0;
            frm       <= '0;
            fflags_q  <= '0;
            irq_en_q  <= '0;
            busy_q    <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_err_q <= 1'b0;
            ovf_q     <= 1'b0;
            inter_gen <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (wren && (off == OFF_A)) opA <= wrdata;
            if (wren && (off == OFF_B)) opB <= wrdata;
            if (wren && (off == OFF_C)) opC <= wrdata;
            if (wren && (off == OFF_IRQ_EN)) irq_en_q <= wrdata[2:0];
            if (op_wr_ok) op_valids <= wrdata[NUM_OPS-1:0];

            frm       <= frm_n;
            fflags_q  <= fflags_n;
            busy_q    <= busy_n;
            cmd_valid <= cmd_valid_n;
            cmd_err_q <= cmd_err_n;
            ovf_q     <= ovf_n;
            count     <= count_n;

            if (push) begin
                fifo_mem[wr_ptr] <= {fpu_valids, fpu_result};
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            inter_gen <= (irq_en_q[0] && !fifo_empty) ||
                         (irq_en_q[1] && ovf_q) ||
                         (irq_en_q[2] && cmd_err_q);
        end
    end

endmodule

// File: tb/tb_fpu_cmd_regs.sv
module tb_fpu_cmd_regs;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] R_A    = 32'h00;
    localparam logic [31:0] R_B    = 32'h04;
    localparam logic [31:0] R_C    = 32'h08;
    localparam logic [31:0] R_RES  = 32'h0C;
    localparam logic [31:0] R_ROP  = 32'h10;
    localparam logic [31:0] R_ST   = 32'h14;
    localparam logic [31:0] R_IRQ  = 32'h18;
    localparam logic [31:0] R_OP   = 32'h1C;
    localparam logic [31:0] R_FF   = 32'h20;
    localparam logic [31:0] R_FRM  = 32'h24;
    localparam logic [31:0] R_FCSR = 32'h28;
    localparam logic [12:0] MASK   = 13'h1FFC;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic [31:0] addr = BASE;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    logic [31:0] wrdata = '0;
    logic [31:0] rddata;
    logic [31:0] opA, opB, opC;
    logic [2:0]  frm;
    logic [12:0] op_valids;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [31:0] fpu_result = '0;
    logic [12:0] fpu_valids = '0;
    logic [4:0]  exceptions = '0;
    logic        inter_gen;

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard of {op tag, result} entries the FIFO should be holding
    logic [44:0] sb[$];

    fpu_cmd_regs dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .addr       (addr),
        .wren       (wren),
        .rden       (rden),
        .wrdata     (wrdata),
        .rddata     (rddata),
        .opA        (opA),
        .opB        (opB),
        .opC        (opC),
        .frm        (frm),
        .op_valids  (op_valids),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .fpu_result (fpu_result),
        .fpu_valids (fpu_valids),
        .exceptions (exceptions),
        .inter_gen  (inter_gen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [31:0] off, input logic [31:0] data);
        addr   = BASE + off;
        wrdata = data;
        wren   = 1'b1;
        tick();
        wren   = 1'b0;
    endtask

    task automatic rd_reg(input logic [31:0] off, output logic [31:0] d);
        addr = BASE + off;
        rden = 1'b1;
        #2 d = rddata;
        tick();
        rden = 1'b0;
    endtask

    // Model push: only masked-in valids are results; a full FIFO drops them
    task automatic model_result(input logic [31:0] val, input logic [12:0] op);
        if (|(op & MASK) && sb.size() < 4) sb.push_back({op, val});
    endtask

    task automatic fpu_done(input logic [31:0] val, input logic [12:0] op, input logic [4:0] exc);
        fpu_result = val;
        fpu_valids = op;
        exceptions = exc;
        model_result(val, op);
        tick();
        fpu_valids = '0;
        exceptions = '0;
    endtask

    task automatic check_result(input string tag);
        logic [44:0] e;
        logic [31:0] exp;
        logic [31:0] d;
        exp = '0;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            exp = e[31:0];
        end
        rd_reg(R_RES, d);
        check(tag, d, exp);
    endtask

    task automatic check_head_op(input string tag);
        logic [44:0] e;
        logic [31:0] exp;
        logic [31:0] d;
        exp = '0;
        if (sb.size() > 0) begin
            e   = sb[0];
            exp = {19'b0, e[44:32]};
        end
        rd_reg(R_ROP, d);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic [44:0] e;
        int hi;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_opA", opA, 32'h0);
        check("rst_cmd_valid", {31'b0, cmd_valid}, 32'h0);
        check("rst_op_valids", {19'b0, op_valids}, 32'h0);
        check("rst_inter_gen", {31'b0, inter_gen}, 32'h0);
        rst_l = 1'b1;
        tick();
        rd_reg(R_ST, d);
        check("rst_status", d, 32'h0);

        // Launch: operands, operation, cmd_ready on the third cycle of cmd_valid
        wr_reg(R_A, 32'h3F80_0000);
        wr_reg(R_B, 32'h4000_0000);
        check("opA", opA, 32'h3F80_0000);
        check("opB", opB, 32'h4000_0000);
        wr_reg(R_OP, 32'h4);
        check("op_valids", {19'b0, op_valids}, 32'h4);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (!cmd_valid) break;
            hi++;
            cmd_ready = (i == 2);
            tick();
        end
        cmd_ready = 1'b0;
        check("cmd_valid_cycles", hi, 32'd3);
        rd_reg(R_ST, d);
        check("busy_before_result", d, 32'h100);

        // Single result with exceptions
        fpu_done(32'h4040_0000, 13'h4, 5'h01);
        rd_reg(R_ST, d);
        check("status_one_result", d, 32'h001);
        check_head_op("result_op_head");
        check_result("result_pop");
        rd_reg(R_ST, d);
        check("status_after_pop", d, 32'h000);
        rd_reg(R_FF, d);
        check("fflags_accum", d, 32'h1);

        // Valid bits outside the mask do not count as a result
        fpu_done(32'hDEAD_BEEF, 13'h3, 5'h0);
        rd_reg(R_ST, d);
        check("masked_valids", d, 32'h000);

        // Overflow: five results into four entries
        for (int i = 0; i < 5; i++) fpu_done(32'd100 + i, 13'h4 << i, 5'h0);
        rd_reg(R_ST, d);
        check("status_full_ovf", d, 32'h204);
        check_head_op("ovf_head_op");
        for (int i = 0; i < 4; i++) check_result($sformatf("ovf_pop%0d", i));
        check_result("empty_pop");
        rd_reg(R_ST, d);
        check("ovf_sticky", d, 32'h200);
        wr_reg(R_ST, 32'h200);
        rd_reg(R_ST, d);
        check("ovf_cleared", d, 32'h000);

        // Simultaneous pop and push at full occupancy
        for (int i = 0; i < 4; i++) fpu_done(32'h10 + i, 13'h8, 5'h0);
        addr       = BASE + R_RES;
        rden       = 1'b1;
        fpu_result = 32'h99;
        fpu_valids = 13'h10;
        #2 d = rddata;
        e = sb.pop_front();
        check("popush_head", d, e[31:0]);
        model_result(32'h99, 13'h10);
        tick();
        rden       = 1'b0;
        fpu_valids = '0;
        rd_reg(R_ST, d);
        check("popush_status", d, 32'h004);
        for (int i = 0; i < 4; i++) check_result($sformatf("popush_drain%0d", i));

        // Operation write while busy
        wr_reg(R_OP, 32'h8);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("cmd_valid_drop", {31'b0, cmd_valid}, 32'h0);
        wr_reg(R_OP, 32'h10);
        check("op_held_busy", {19'b0, op_valids}, 32'h8);
        rd_reg(R_ST, d);
        check("cmd_err_set", d, 32'h500);
        wr_reg(R_IRQ, 32'h4);
        check("irq_latency", {31'b0, inter_gen}, 32'h0);
        tick();
        check("irq_cmd_err", {31'b0, inter_gen}, 32'h1);
        wr_reg(R_ST, 32'h400);
        rd_reg(R_ST, d);
        check("cmd_err_clear", d, 32'h100);
        check("irq_drop", {31'b0, inter_gen}, 32'h0);

        // Rounding mode / flags registers
        wr_reg(R_FRM, 32'h3);
        check("frm_write", {29'b0, frm}, 32'h3);
        wr_reg(R_FCSR, 32'hA5);
        rd_reg(R_FCSR, d);
        check("fcsr_read", d, 32'hA5);
        check("frm_from_fcsr", {29'b0, frm}, 32'h5);
        addr       = BASE + R_FF;
        wrdata     = 32'h02;
        wren       = 1'b1;
        fpu_result = 32'h55;
        fpu_valids = 13'h8;
        exceptions = 5'h10;
        model_result(32'h55, 13'h8);
        tick();
        wren       = 1'b0;
        fpu_valids = '0;
        exceptions = '0;
        rd_reg(R_FF, d);
        check("fflags_write_or_exc", d, 32'h12);
        rd_reg(32'h2C, d);
        check("unmapped_read", d, 32'h0);

        // Busy with two entries queued, then reset with a result arriving
        fpu_done(32'h77, 13'h4, 5'h0);
        wr_reg(R_OP, 32'h20);
        wr_reg(R_IRQ, 32'h1);
        wr_reg(R_C, 32'h00C0_FFEE);
        check("opC", opC, 32'h00C0_FFEE);
        check("irq_count", {31'b0, inter_gen}, 32'h1);
        rd_reg(R_ST, d);
        check("pre_reset_status", d, 32'h102);
        rst_l      = 1'b0;
        fpu_result = 32'h1234;
        fpu_valids = 13'h4;
        tick();
        check("reset_opA", opA, 32'h0);
        check("reset_opC", opC, 32'h0);
        check("reset_frm", {29'b0, frm}, 32'h0);
        check("reset_op_valids", {19'b0, op_valids}, 32'h0);
        check("reset_cmd_valid", {31'b0, cmd_valid}, 32'h0);
        check("reset_inter_gen", {31'b0, inter_gen}, 32'h0);
        rst_l      = 1'b1;
        fpu_valids = '0;
        sb.delete();
        check_result("post_reset_result");
        rd_reg(R_ST, d);
        check("post_reset_status", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fpu_cmd_regs.md
FPU_CMD_REGS -- requirements
Module: fpu_cmd_regs

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000: base of the 32-bit register map.
REQ-002 SHALL have parameter NUM_OPS, default 13: width of the one-hot operation select.
REQ-003 SHALL have parameter DEPTH, default 4 (power of two, >=2): result FIFO entries.
REQ-004 SHALL have parameter VALID_MASK, NUM_OPS bits, default 13'h1FFC: fpu_valids bits that denote a result.
REQ-005 SHALL have port clk, in, 1: the single clock, all state on rising edge.
REQ-006 SHALL have port rst_l, in, 1: reset, synchronous and active-low.
REQ-007 SHALL have ports addr in 32, wren in 1, rden in 1, wrdata in 32: bus access.
REQ-008 SHALL have port rddata, out, 32: combinational read data for addr.
REQ-009 SHALL have ports opA, opB, opC, out, 32 each: operand registers.
REQ-010 SHALL have ports frm out 3 (rounding mode) and op_valids out NUM_OPS (latched operation).
REQ-011 SHALL have ports cmd_valid out 1 and cmd_ready in 1: launch handshake to the FPU.
REQ-012 SHALL have ports fpu_result in 32, fpu_valids in NUM_OPS, exceptions in 5: FPU completion.
REQ-013 SHALL have port inter_gen, out, 1: level interrupt.

Function
REQ-014 SHALL decode offsets: 0x00 A, 0x04 B, 0x08 C, 0x0C RESULT, 0x10 RESULT_OP, 0x14 STATUS, 0x18 IRQ_EN, 0x1C OPERATION, 0x20 FFLAGS, 0x24 FRM, 0x28 FCSR; all others read 0, writes ignored.
REQ-015 SHALL update A/B/C on wren to their address, next edge.
REQ-016 SHALL accept an OPERATION write only when wrdata[NUM_OPS-1:0]!=0 and busy=0: latch op_valids, set busy and cmd_valid next cycle.
REQ-017 SHALL hold cmd_valid high until the cycle cmd_ready=1, then deassert it next edge.
REQ-018 SHALL ignore an OPERATION write while busy=1 and set sticky STATUS.cmd_err; zero writes are ignored without error.
REQ-019 SHALL detect a result when |(fpu_valids & VALID_MASK), clear busy next edge, and OR exceptions into fflags.
REQ-020 SHALL push {fpu_valids, fpu_result} into the FIFO on a result when not full; when full with no pop that cycle, drop it and set sticky STATUS.ovf.
REQ-021 SHALL pop the head on rden with addr=RESULT; rddata shows head result that cycle; empty-pop returns 0, no state change.
REQ-022 SHALL accept simultaneous push and pop in any occupancy, count unchanged, no ovf when full.
REQ-023 SHALL return head op tag on RESULT_OP (zero-extended, 0 when empty), no pop.
REQ-024 SHALL read STATUS as {cmd_err[10], ovf[9], busy[8], count[7:0]}; writing 1 to bits 10/9 clears them, and a same-cycle set wins.
REQ-025 SHALL register inter_gen = (IRQ_EN[0] & count!=0) | (IRQ_EN[1] & ovf) | (IRQ_EN[2] & cmd_err), one-cycle latency.
REQ-026 SHALL write FFLAGS from wrdata[4:0], FRM from wrdata[2:0], FCSR as {frm=wrdata[7:5], fflags=wrdata[4:0]}; a same-cycle result ORs exceptions into the written value.
REQ-027 SHALL read FCSR as {24'b0, frm, fflags}.
REQ-028 SHALL wrap FIFO pointers modulo DEPTH; count spans 0..DEPTH.

Reset
REQ-029 SHALL, on rst_l=0 at a clock edge, clear all registers, FIFO pointers, count, busy, cmd_valid, sticky bits, IRQ_EN, frm, fflags, inter_gen to 0, regardless of in-flight operation.
REQ-030 SHALL ignore results arriving during reset.

Verification
REQ-031 Write A=3F800000, B=40000000, OPERATION=0x4, cmd_ready after 2 cycles -> cmd_valid high 3 cycles, busy=1 until result.
REQ-032 Result 40400000 with exceptions=5'h01 -> count=1, RESULT reads 40400000 and pops, count=0, FFLAGS=1.
REQ-033 Five results, DEPTH=4, no pops -> count=4, ovf=1; oldest four read in order; STATUS write 0x200 clears ovf.
REQ-034 Pop and result same cycle at count=4 -> count stays 4, ovf stays 0, new entry at tail.
REQ-035 OPERATION write while busy -> op_valids unchanged, cmd_err=1; IRQ_EN=4 -> inter_gen=1 next cycle.
REQ-036 Reset asserted with busy=1, count=2 -> all outputs 0 next edge; post-reset RESULT reads 0.
